uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: start, 8 data bits MSB first, even-XOR parity,
// stop, then one guard bit time before the next frame may start.
module uart_tx_fifo #(
  parameter int CYCLES_PER_BIT = 14,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_3125,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GUARD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;
  logic               done_q, done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic [2:0]         idx_dec;
  logic [7:0]         head_byte;

  assign full      = (count_q == FULL_COUNT);
  assign empty     = (count_q == '0);
  assign tx_ready  = !rst && !full;
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (cnt_q == CNT_LAST);
  assign idx_dec   = idx_q - 3'd1;
  assign head_byte = mem_q[rd_ptr_q];

  // FSM next state; the pop is decided here and also drives the FIFO read side.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
    pop      = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        pop   = !empty;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd7;
          tx_d    = shreg_q[7];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd0) begin
            state_d = S_PARITY;
            tx_d    = parity_q;
          end else begin
            idx_d = idx_dec;
            tx_d  = shreg_q[idx_dec];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_GUARD;
          tx_d    = 1'b1;
        end
      end
      S_GUARD: begin
        // A waiting byte starts on the guard's last edge so queued frames stay 12 bit times apart.
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          tx_d    = 1'b1;
          pop     = !empty;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      state_d  = S_START;
      cnt_d    = '0;
      shreg_d  = head_byte;
      parity_d = ^head_byte;
      tx_d     = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_3125 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd7;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk_3125) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  assign tx         = tx_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE) || !empty;

endmodule
